// File: rtl/instr_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_if
//   Groups the instruction-side handshake and the instruction-memory write
//   port of the instruction encoder into one bundle.
//
//   Signals:
//     load_base  : one-cycle pulse that restarts the encoder at base_addr
//     base_addr  : first instruction-memory address to write (AW bits)
//     in_valid   : instruction fields below are valid this cycle
//     in_ready   : encoder accepts the fields this cycle
//     opcode, op, rn, rd, rm, shift, cond, imm : instruction fields
//     mem_write  : registered write strobe to instruction memory
//     mem_addr   : registered write address (AW bits)
//     mem_din    : registered 16-bit encoded instruction word
//     err        : one-cycle pulse, an illegal instruction was rejected
//     err_sticky : a rejection happened since the last reset / load_base
//     done       : encoder has filled memory up to the last address
//
//   Modports:
//     master : the instruction producer / memory observer side
//     slave  : the encoder itself
// ---------------------------------------------------------------------------
interface instr_encoder_if #(
  parameter int AW = 8
);

  logic          load_base;
  logic [AW-1:0] base_addr;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    opcode;
  logic [1:0]    op;
  logic [2:0]    rn;
  logic [2:0]    rd;
  logic [2:0]    rm;
  logic [1:0]    shift;
  logic [2:0]    cond;
  logic [7:0]    imm;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic          err;
  logic          err_sticky;
  logic          done;

  modport master (
    output load_base, base_addr, in_valid,
    output opcode, op, rn, rd, rm, shift, cond, imm,
    input  in_ready, mem_write, mem_addr, mem_din, err, err_sticky, done
  );

  modport slave (
    input  load_base, base_addr, in_valid,
    input  opcode, op, rn, rd, rm, shift, cond, imm,
    output in_ready, mem_write, mem_addr, mem_din, err, err_sticky, done
  );

endinterface

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Accepts decoded instruction fields over a valid/ready handshake, packs
//   each legal instruction into a 16-bit word, buffers the words in a small
//   FIFO and writes them one per cycle into instruction memory at
//   consecutive addresses starting from a loadable base address. Illegal
//   instructions are consumed but dropped and flagged on err / err_sticky.
//   Once the write at the last address (all ones) has been issued the block
//   parks in DONE until the next load_base.
//
//   Parameters:
//     DEPTH : number of FIFO entries (power of two, >= 2)
//     AW    : instruction-memory address width
//
//   Ports:
//     clk   : sole clock, rising edge
//     reset : asynchronous reset, active low
//     bus   : instr_encoder_if slave modport (handshake, fields, memory port,
//             status)
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  instr_encoder_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_e;

  state_e        state_q, state_d;

  logic [15:0]   fifo_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] wrAddr_q, wrAddr_d;
  logic          memWrite_q, memWrite_d;
  logic [AW-1:0] memAddr_q, memAddr_d;
  logic [15:0]   memDin_q, memDin_d;
  logic          err_q, err_d;
  logic          errSticky_q, errSticky_d;

  logic          legal;
  logic [15:0]   word;
  logic          inReady;
  logic          accept;
  logic          enqueue;
  logic          drain;
  logic          lastAddr;

  // Instruction packing. Every opcode/op pair is checked here; anything not
  // in the table, or a load/store whose immediate does not fit a signed
  // 5-bit offset, comes out with legal = 0 and is dropped after handshake.
  always_comb begin
    legal = 1'b1;
    word  = 16'h0000;
    case (bus.opcode)
      3'b110: begin
        if (bus.op == 2'b10) begin
          word = {3'b110, 2'b10, bus.rn, bus.imm};
        end else if (bus.op == 2'b00) begin
          word = {3'b110, 2'b00, 3'b000, bus.rd, bus.shift, bus.rm};
        end else begin
          legal = 1'b0;
        end
      end
      3'b101: begin
        word = {3'b101, bus.op, bus.rn, bus.rd, bus.shift, bus.rm};
      end
      3'b011, 3'b100: begin
        // the upper immediate bits must be copies of bit 4 (sign extension)
        word  = {bus.opcode, 2'b00, bus.rn, bus.rd, bus.imm[4:0]};
        legal = (bus.op == 2'b00) && (bus.imm[7:5] == {3{bus.imm[4]}});
      end
      3'b001: begin
        word  = {3'b001, 2'b00, bus.cond, bus.imm};
        legal = (bus.op == 2'b00);
      end
      3'b111: begin
        word = 16'hE000;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // Handshake and FIFO control. load_base wins over everything, so it both
  // blocks acceptance and suppresses the drain on its edge.
  always_comb begin
    inReady  = (state_q == ACTIVE) && (count_q < FULL_C) && !bus.load_base;
    accept   = bus.in_valid && inReady;
    enqueue  = accept && legal;
    drain    = (state_q == ACTIVE) && (count_q != '0) && !bus.load_base;
    lastAddr = &wrAddr_q;
  end

  // State machine next-state logic. The write at the all-ones address is the
  // final one; the machine then sits in DONE holding any leftover words.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.load_base) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (bus.load_base) begin
          state_d = ACTIVE;
        end else if (drain && lastAddr) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.load_base) begin
          state_d = ACTIVE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath next-state: pointers, occupancy, memory port and error flags.
  // The address pointer saturates at all ones instead of wrapping, because
  // reaching it ends the run.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    wrAddr_d    = wrAddr_q;
    memWrite_d  = 1'b0;
    memAddr_d   = memAddr_q;
    memDin_d    = memDin_q;
    err_d       = 1'b0;
    errSticky_d = errSticky_q;

    if (bus.load_base) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      wrAddr_d    = bus.base_addr;
      errSticky_d = 1'b0;
    end else begin
      if (drain) begin
        memWrite_d = 1'b1;
        memAddr_d  = wrAddr_q;
        memDin_d   = fifo_q[head_q];
        head_d     = head_q + PW'(1);
        if (!lastAddr) begin
          wrAddr_d = wrAddr_q + AW'(1);
        end
      end
      if (enqueue) begin
        tail_d = tail_q + PW'(1);
      end
      if (accept && !legal) begin
        err_d       = 1'b1;
        errSticky_d = 1'b1;
      end
      case ({enqueue, drain})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control and output registers. Reset clears everything including the
  // pending write strobe, so nothing half-written leaks out afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      wrAddr_q    <= '0;
      memWrite_q  <= 1'b0;
      memAddr_q   <= '0;
      memDin_q    <= '0;
      err_q       <= 1'b0;
      errSticky_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      wrAddr_q    <= wrAddr_d;
      memWrite_q  <= memWrite_d;
      memAddr_q   <= memAddr_d;
      memDin_q    <= memDin_d;
      err_q       <= err_d;
      errSticky_q <= errSticky_d;
    end
  end

  // FIFO storage needs no reset: occupancy is tracked by count/head/tail,
  // and a word is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (enqueue) begin
      fifo_q[tail_q] <= word;
    end
  end

  assign bus.in_ready   = inReady;
  assign bus.mem_write  = memWrite_q;
  assign bus.mem_addr   = memAddr_q;
  assign bus.mem_din    = memDin_q;
  assign bus.err        = err_q;
  assign bus.err_sticky = errSticky_q;
  assign bus.done       = (state_q == DONE);

endmodule
